// File: rtl/dmem_pkg.sv
// Shared types and helpers for the data-memory responder: FSM encoding and
// the address legality check used to gate array access.
package dmem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam int ADDR_LSB = 2;

    // Misaligned, or any address bit above the array's word index set.
    function automatic logic is_bad_addr(input logic [31:0] addr, input int depth_log2);
        logic [31:0] hi;
        hi = addr >> (depth_log2 + ADDR_LSB);
        return (addr[1:0] != 2'b00) || (hi != 32'd0);
    endfunction

endpackage

// File: rtl/dmem_array.sv
// Word-organised synchronous RAM with per-byte write enables and a registered
// read port. Contents are deliberately not reset.
module dmem_array #(
    parameter int DEPTH_LOG2 = 8
) (
    input  logic                  clk,
    input  logic [3:0]            we,
    input  logic                  re,
    input  logic [DEPTH_LOG2-1:0] addr,
    input  logic [31:0]           wdata,
    output logic [31:0]           rdata
);

    logic [31:0] mem [2**DEPTH_LOG2];

    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (we[i]) begin
                mem[addr][8*i +: 8] <= wdata[8*i +: 8];
            end
        end
        if (re) begin
            rdata <= mem[addr];
        end
    end

endmodule

// File: rtl/dmem_responder.sv
// Multi-cycle load/store responder for the core's data port: valid/ready
// request, one-cycle response pulse, and a stall for the hazard unit.
//
// state | meaning
// IDLE  | ready for a request, nothing outstanding
// WAIT  | request captured, counting down to the access edge
// RESP  | response pulse; a new request may be accepted back-to-back
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int DEPTH_LOG2 = 8,
    parameter int LATENCY    = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [3:0]  req_wstrb,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic        stall
);

    if (LATENCY < 1 || LATENCY > 7) begin : g_bad_latency
        $error("dmem_responder: LATENCY must be in 1..7");
    end

    localparam logic [2:0] CNT_INIT = (LATENCY > 1) ? 3'(LATENCY - 2) : 3'd0;

    state_t      state, state_nx;
    logic [2:0]  cnt, cnt_nx;
    logic        accept;
    logic        enter_resp;

    logic        cap_we;
    logic [3:0]  cap_wstrb;
    logic [31:0] cap_addr;
    logic [31:0] cap_wdata;

    logic        acc_we;
    logic [3:0]  acc_wstrb;
    logic [31:0] acc_addr;
    logic [31:0] acc_wdata;
    logic        acc_bad;

    logic [3:0]  mem_we;
    logic        mem_re;
    logic [31:0] mem_rdata;
    logic        err_q;
    logic        load_ok_q;

    assign req_ready = (state != WAIT);
    assign accept    = req_valid & req_ready;
    assign stall     = (state == WAIT) | accept;

    always_comb begin
        state_nx   = state;
        cnt_nx     = cnt;
        enter_resp = 1'b0;
        case (state)
            IDLE, RESP: begin
                if (accept) begin
                    if (LATENCY == 1) begin
                        state_nx   = RESP;
                        enter_resp = 1'b1;
                    end else begin
                        state_nx = WAIT;
                        cnt_nx   = CNT_INIT;
                    end
                end else begin
                    state_nx = IDLE;
                end
            end
            WAIT: begin
                if (cnt == 3'd0) begin
                    state_nx   = RESP;
                    enter_resp = 1'b1;
                end else begin
                    cnt_nx = cnt - 3'd1;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // With LATENCY==1 the access happens on the accept edge itself, so the
    // live request fields are used instead of the (not yet loaded) capture.
    always_comb begin
        acc_we    = req_we;
        acc_wstrb = req_wstrb;
        acc_addr  = req_addr;
        acc_wdata = req_wdata;
        if (state == WAIT) begin
            acc_we    = cap_we;
            acc_wstrb = cap_wstrb;
            acc_addr  = cap_addr;
            acc_wdata = cap_wdata;
        end
    end

    assign acc_bad = is_bad_addr(acc_addr, DEPTH_LOG2);
    assign mem_we  = (enter_resp && acc_we && !acc_bad) ? acc_wstrb : 4'b0000;
    assign mem_re  = enter_resp && !acc_we && !acc_bad;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            cnt       <= 3'd0;
            cap_we    <= 1'b0;
            cap_wstrb <= 4'b0000;
            cap_addr  <= 32'd0;
            cap_wdata <= 32'd0;
            err_q     <= 1'b0;
            load_ok_q <= 1'b0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
            if (accept) begin
                cap_we    <= req_we;
                cap_wstrb <= req_wstrb;
                cap_addr  <= req_addr;
                cap_wdata <= req_wdata;
            end
            if (enter_resp) begin
                err_q     <= acc_bad;
                load_ok_q <= !acc_we && !acc_bad;
            end
        end
    end

    dmem_array #(
        .DEPTH_LOG2(DEPTH_LOG2)
    ) u_array (
        .clk  (clk),
        .we   (mem_we),
        .re   (mem_re),
        .addr (acc_addr[DEPTH_LOG2+ADDR_LSB-1:ADDR_LSB]),
        .wdata(acc_wdata),
        .rdata(mem_rdata)
    );

    // Response fields are held at zero outside the RESP pulse.
    assign resp_valid = (state == RESP);
    assign resp_err   = resp_valid & err_q;
    assign resp_rdata = (resp_valid && load_ok_q) ? mem_rdata : 32'd0;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: three instances at LATENCY 1, 2 and 4
// share one clock; each step checks against hand-computed values.
module tb_dmem_responder;

    logic        clk;
    logic [2:0]  rst;
    logic [2:0]  req_valid;
    logic [2:0]  req_ready;
    logic [2:0]  req_we;
    logic [3:0]  req_wstrb [3];
    logic [31:0] req_addr  [3];
    logic [31:0] req_wdata [3];
    logic [2:0]  resp_valid;
    logic [31:0] resp_rdata [3];
    logic [2:0]  resp_err;
    logic [2:0]  stall;

    int n_checks = 0;
    int n_fail   = 0;

    // instance 0: LATENCY 1, instance 1: LATENCY 2, instance 2: LATENCY 4
    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int LAT = (g == 0) ? 1 : ((g == 1) ? 2 : 4);
        dmem_responder #(
            .DEPTH_LOG2(8),
            .LATENCY   (LAT)
        ) u_dut (
            .clk       (clk),
            .rst       (rst[g]),
            .req_valid (req_valid[g]),
            .req_ready (req_ready[g]),
            .req_we    (req_we[g]),
            .req_wstrb (req_wstrb[g]),
            .req_addr  (req_addr[g]),
            .req_wdata (req_wdata[g]),
            .resp_valid(resp_valid[g]),
            .resp_rdata(resp_rdata[g]),
            .resp_err  (resp_err[g]),
            .stall     (stall[g])
        );
    end

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One request on instance d; returns response fields, edges from accept to
    // the response cycle, and the number of sampled cycles with stall high.
    task automatic xact(input int d, input logic we, input logic [3:0] ws,
                        input logic [31:0] a, input logic [31:0] wd, input bit tog,
                        output logic [31:0] rd, output logic er,
                        output int lat, output int stl);
        @(negedge clk);
        req_valid[d] = 1'b1;
        req_we[d]    = we;
        req_wstrb[d] = ws;
        req_addr[d]  = a;
        req_wdata[d] = wd;
        #1;
        stl = int'(stall[d]);
        @(negedge clk);
        req_valid[d] = 1'b0;
        lat = 1;
        #1;
        while (!resp_valid[d] && lat < 20) begin
            stl += int'(stall[d]);
            if (tog) begin
                req_addr[d]  = 32'h0000_0013 + 32'(lat);
                req_wdata[d] = 32'hFFFF_0000 ^ 32'(lat);
                req_we[d]    = ~we;
            end
            @(negedge clk);
            lat++;
            #1;
        end
        stl += int'(stall[d]);
        rd = resp_rdata[d];
        er = resp_err[d];
    endtask

    initial begin
        logic [31:0] rd;
        logic        er;
        int          lat;
        int          stl;

        rst       = 3'b000;
        req_valid = 3'b000;
        req_we    = 3'b000;
        for (int i = 0; i < 3; i++) begin
            req_wstrb[i] = 4'h0;
            req_addr[i]  = 32'd0;
            req_wdata[i] = 32'd0;
        end
        #12;
        for (int i = 0; i < 3; i++) begin
            check($sformatf("rst_ready%0d", i), 32'(req_ready[i]), 32'd1);
            check($sformatf("rst_valid%0d", i), 32'(resp_valid[i]), 32'd0);
            check($sformatf("rst_rdata%0d", i), resp_rdata[i], 32'd0);
            check($sformatf("rst_err%0d", i), 32'(resp_err[i]), 32'd0);
            check($sformatf("rst_stall%0d", i), 32'(stall[i]), 32'd0);
        end
        @(negedge clk);
        rst = 3'b111;

        // Full-word store then load, LATENCY 2
        xact(1, 1'b1, 4'hF, 32'h10, 32'hDEAD_BEEF, 1'b0, rd, er, lat, stl);
        check("st_lat", 32'(lat), 32'd2);
        check("st_stall", 32'(stl), 32'd2);
        check("st_err", 32'(er), 32'd0);
        check("st_rdata", rd, 32'd0);
        xact(1, 1'b0, 4'h0, 32'h10, 32'd0, 1'b0, rd, er, lat, stl);
        check("ld_lat", 32'(lat), 32'd2);
        check("ld_stall", 32'(stl), 32'd2);
        check("ld_rdata", rd, 32'hDEAD_BEEF);
        check("ld_err", 32'(er), 32'd0);

        // Partial-lane store
        xact(1, 1'b1, 4'b0001, 32'h10, 32'h0000_00AA, 1'b0, rd, er, lat, stl);
        xact(1, 1'b0, 4'h0, 32'h10, 32'd0, 1'b0, rd, er, lat, stl);
        check("byte_merge", rd, 32'hDEAD_BEAA);
        xact(1, 1'b1, 4'b0000, 32'h10, 32'h1234_5678, 1'b0, rd, er, lat, stl);
        check("nostrb_err", 32'(er), 32'd0);
        xact(1, 1'b0, 4'h0, 32'h10, 32'd0, 1'b0, rd, er, lat, stl);
        check("nostrb_keep", rd, 32'hDEAD_BEAA);

        // Error paths; 0x400 would alias word 0 if the range check were lost
        xact(1, 1'b1, 4'hF, 32'h0, 32'h0102_0304, 1'b0, rd, er, lat, stl);
        xact(1, 1'b0, 4'h0, 32'h12, 32'd0, 1'b0, rd, er, lat, stl);
        check("misal_err", 32'(er), 32'd1);
        check("misal_rdata", rd, 32'd0);
        xact(1, 1'b1, 4'hF, 32'h400, 32'hFFFF_FFFF, 1'b0, rd, er, lat, stl);
        check("oor_err", 32'(er), 32'd1);
        check("oor_rdata", rd, 32'd0);
        xact(1, 1'b0, 4'h0, 32'h0, 32'd0, 1'b0, rd, er, lat, stl);
        check("oor_nowrite", rd, 32'h0102_0304);
        check("oor_nowrite_err", 32'(er), 32'd0);
        xact(1, 1'b0, 4'h0, 32'h8000_0010, 32'd0, 1'b0, rd, er, lat, stl);
        check("hi_addr_err", 32'(er), 32'd1);

        // LATENCY 1 back-to-back: 8 stores then 8 loads, one per cycle
        for (int k = 0; k <= 8; k++) begin
            @(negedge clk);
            if (k > 0) begin
                check($sformatf("b2b_st_valid%0d", k), 32'(resp_valid[0]), 32'd1);
                check($sformatf("b2b_st_err%0d", k), 32'(resp_err[0]), 32'd0);
            end
            if (k < 8) begin
                req_valid[0] = 1'b1;
                req_we[0]    = 1'b1;
                req_wstrb[0] = 4'hF;
                req_addr[0]  = 32'(4 * k);
                req_wdata[0] = 32'h1111_1111 * 32'(k + 1);
                #1;
                check($sformatf("b2b_st_ready%0d", k), 32'(req_ready[0]), 32'd1);
                check($sformatf("b2b_st_stall%0d", k), 32'(stall[0]), 32'd1);
            end else begin
                req_valid[0] = 1'b0;
            end
        end
        for (int k = 0; k <= 8; k++) begin
            @(negedge clk);
            if (k > 0) begin
                check($sformatf("b2b_ld_valid%0d", k), 32'(resp_valid[0]), 32'd1);
                check($sformatf("b2b_ld_rdata%0d", k), resp_rdata[0], 32'h1111_1111 * 32'(k));
            end
            if (k < 8) begin
                req_valid[0] = 1'b1;
                req_we[0]    = 1'b0;
                req_addr[0]  = 32'(4 * k);
                #1;
                check($sformatf("b2b_ld_ready%0d", k), 32'(req_ready[0]), 32'd1);
                check($sformatf("b2b_ld_stall%0d", k), 32'(stall[0]), 32'd1);
            end else begin
                req_valid[0] = 1'b0;
            end
        end
        @(negedge clk);
        check("b2b_end_valid", 32'(resp_valid[0]), 32'd0);

        // LATENCY 4 with asynchronous reset mid-WAIT
        xact(2, 1'b1, 4'hF, 32'h20, 32'hCAFE_F00D, 1'b0, rd, er, lat, stl);
        check("l4_lat", 32'(lat), 32'd4);
        check("l4_stall", 32'(stl), 32'd4);
        @(negedge clk);
        req_valid[2] = 1'b1;
        req_we[2]    = 1'b1;
        req_wstrb[2] = 4'hF;
        req_addr[2]  = 32'h20;
        req_wdata[2] = 32'h1234_5678;
        @(negedge clk);
        req_valid[2] = 1'b0;
        #1;
        check("wait_ready", 32'(req_ready[2]), 32'd0);
        check("wait_stall", 32'(stall[2]), 32'd1);
        #1;
        rst[2] = 1'b0;
        #1;
        check("arst_ready", 32'(req_ready[2]), 32'd1);
        check("arst_stall", 32'(stall[2]), 32'd0);
        check("arst_valid", 32'(resp_valid[2]), 32'd0);
        repeat (3) @(negedge clk);
        rst[2] = 1'b1;
        xact(2, 1'b0, 4'h0, 32'h20, 32'd0, 1'b0, rd, er, lat, stl);
        check("arst_discard", rd, 32'hCAFE_F00D);

        // Request fields change during WAIT; only the captured ones count
        xact(2, 1'b1, 4'hF, 32'h24, 32'hA5A5_A5A5, 1'b1, rd, er, lat, stl);
        check("tog_st_err", 32'(er), 32'd0);
        xact(2, 1'b0, 4'h0, 32'h24, 32'd0, 1'b1, rd, er, lat, stl);
        check("tog_ld_rdata", rd, 32'hA5A5_A5A5);
        check("tog_ld_err", 32'(er), 32'd0);
        check("tog_ld_lat", 32'(lat), 32'd4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
